// File: rtl/text_cursor_ctrl.sv
// Keyboard-to-screen text cursor: queues ASCII keys, interprets control codes,
// moves the cursor and hands printable glyphs to a plotter over a req/ack handshake.
module text_cursor_ctrl #(
    parameter int COLS  = 40,
    parameter int ROWS  = 15,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [6:0] key_ascii,
    input  logic       draw_ack,
    output logic       draw_req,
    output logic [8:0] draw_x,
    output logic [9:0] draw_y,
    output logic [6:0] draw_char,
    output logic [5:0] cursor_col,
    output logic [3:0] cursor_row,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [5:0]       COL_LAST = 6'(COLS - 1);
    localparam logic [3:0]       ROW_LAST = 4'(ROWS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_DRAW    = 2'd2;
    localparam logic [1:0] ST_ADVANCE = 2'd3;

    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_LF    = 7'h0A;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    logic [6:0]       mem_q [DEPTH];
    logic [6:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [1:0] state_q, state_d;
    logic [6:0] char_q, char_d;
    logic       adv_q, adv_d;
    logic [5:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       draw_req_q, draw_req_d;
    logic [8:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;
    logic [6:0] draw_char_q, draw_char_d;

    logic       pop_s;
    logic       push_s;
    logic [5:0] bs_col_s;
    logic [3:0] bs_row_s;
    logic [3:0] nxt_row_s;

    // A push is still allowed when full if the head leaves in the same cycle.
    assign pop_s  = (state_q == ST_IDLE) && (count_q != CNT_ZERO);
    assign push_s = key_valid && ((count_q != CNT_FULL) || pop_s);

    // Key FIFO next-state and sticky drop flag.
    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q | (key_valid & ~push_s);
        if (push_s) begin
            mem_d[wr_ptr_q] = key_ascii;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Backspace target cell and wrapped next row.
    always_comb begin
        if (col_q != 6'd0) begin
            bs_col_s = col_q - 6'd1;
            bs_row_s = row_q;
        end else if (row_q != 4'd0) begin
            bs_col_s = COL_LAST;
            bs_row_s = row_q - 4'd1;
        end else begin
            bs_col_s = col_q;
            bs_row_s = row_q;
        end
        nxt_row_s = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
    end

    // Control FSM: decode, cursor movement and plotter handshake.
    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        adv_d       = adv_q;
        col_d       = col_q;
        row_d       = row_q;
        draw_req_d  = draw_req_q;
        draw_x_d    = draw_x_q;
        draw_y_d    = draw_y_q;
        draw_char_d = draw_char_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    char_d  = mem_q[rd_ptr_q];
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if ((char_q >= ASCII_SPACE) && (char_q <= ASCII_TILDE)) begin
                    draw_char_d = char_q;
                    draw_x_d    = {col_q, 3'b000};
                    draw_y_d    = {2'b00, row_q, 4'b0000};
                    adv_d       = 1'b1;
                    state_d     = ST_DRAW;
                end else if ((char_q == ASCII_CR) || (char_q == ASCII_LF)) begin
                    col_d   = 6'd0;
                    row_d   = nxt_row_s;
                    state_d = ST_IDLE;
                end else if (char_q == ASCII_BS) begin
                    col_d       = bs_col_s;
                    row_d       = bs_row_s;
                    draw_char_d = ASCII_SPACE;
                    draw_x_d    = {bs_col_s, 3'b000};
                    draw_y_d    = {2'b00, bs_row_s, 4'b0000};
                    adv_d       = 1'b0;
                    state_d     = ST_DRAW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                // First DRAW cycle lets the cell coordinates settle before the request rises.
                if (!draw_req_q) begin
                    draw_req_d = 1'b1;
                end else if (draw_ack) begin
                    draw_req_d = 1'b0;
                    state_d    = ST_ADVANCE;
                end else begin
                    draw_req_d = 1'b1;
                end
            end
            ST_ADVANCE: begin
                if (adv_q) begin
                    if (col_q == COL_LAST) begin
                        col_d = 6'd0;
                        row_d = nxt_row_s;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end else begin
                    col_d = col_q;
                end
                adv_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                draw_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 7'h00;
            end
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            state_q     <= ST_IDLE;
            char_q      <= 7'h00;
            adv_q       <= 1'b0;
            col_q       <= 6'd0;
            row_q       <= 4'd0;
            draw_req_q  <= 1'b0;
            draw_x_q    <= 9'd0;
            draw_y_q    <= 10'd0;
            draw_char_q <= 7'h00;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            char_q      <= char_d;
            adv_q       <= adv_d;
            col_q       <= col_d;
            row_q       <= row_d;
            draw_req_q  <= draw_req_d;
            draw_x_q    <= draw_x_d;
            draw_y_q    <= draw_y_d;
            draw_char_q <= draw_char_d;
        end
    end

    assign draw_req   = draw_req_q;
    assign draw_x     = draw_x_q;
    assign draw_y     = draw_y_q;
    assign draw_char  = draw_char_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: a linear-position screen model predicts
// every glyph plot; a monitor pops and compares each time draw_req rises.
module tb_text_cursor_ctrl;

    localparam int COLS  = 40;
    localparam int ROWS  = 15;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [6:0] key_ascii;
    logic       draw_ack;
    logic       draw_req;
    logic [8:0] draw_x;
    logic [9:0] draw_y;
    logic [6:0] draw_char;
    logic [5:0] cursor_col;
    logic [3:0] cursor_row;
    logic       overflow;

    text_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .draw_ack   (draw_ack),
        .draw_req   (draw_req),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_char  (draw_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .overflow   (overflow)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] burst_q[$];
    int checks   = 0;
    int failures = 0;
    int mcol     = 0;
    int mrow     = 0;
    int rise_cnt = 0;
    int last_x   = -1;
    int last_y   = -1;
    int last_c   = -1;
    int ack_delay = 2;
    bit hold_ack  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Screen model: cursor as one linear cell index, plots as a queue of expected cells.
    task automatic model_key(input logic [6:0] k);
        int pos;
        exp_t e;
        pos = mrow * COLS + mcol;
        if (k >= 7'h20 && k <= 7'h7E) begin
            e.x = mcol * 8; e.y = mrow * 16; e.c = int'(k);
            exp_q.push_back(e);
            pos = (pos + 1) % (COLS * ROWS);
        end else if (k == 7'h0D || k == 7'h0A) begin
            pos = ((mrow + 1) % ROWS) * COLS;
        end else if (k == 7'h08) begin
            if (pos > 0) pos = pos - 1;
            e.x = (pos % COLS) * 8; e.y = (pos / COLS) * 16; e.c = 32;
            exp_q.push_back(e);
        end
        mcol = pos % COLS;
        mrow = pos / COLS;
    endtask

    function automatic logic [6:0] rand_print();
        return 7'($urandom_range(32, 126));
    endfunction

    function automatic logic [6:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 7'h08;
            1: return 7'h0D;
            2: return 7'h0A;
            3: begin
                case ($urandom_range(0, 3))
                    0: return 7'h00;
                    1: return 7'h07;
                    2: return 7'h1B;
                    default: return 7'h7F;
                endcase
            end
            default: return rand_print();
        endcase
    endfunction

    task automatic issue_burst(input int nmodel);
        for (int i = 0; i < burst_q.size(); i++) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_ascii = burst_q[i];
            if (i < nmodel) model_key(burst_q[i]);
        end
        @(negedge clk);
        key_valid = 1'b0;
        burst_q.delete();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n >= 3000) ? 1 : 0, 0);
        repeat (20) @(negedge clk);
    endtask

    // Sends n copies of k (0 = random printable) in bursts the FIFO can absorb.
    task automatic type_keys(input logic [6:0] k, input int n);
        int left;
        int m;
        left = n;
        while (left > 0) begin
            m = (left > DEPTH + 1) ? DEPTH + 1 : left;
            for (int i = 0; i < m; i++) burst_q.push_back((k == 7'h00) ? rand_print() : k);
            issue_burst(m);
            wait_drain();
            left = left - m;
        end
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, int'(cursor_col), c);
        chk({name, "_row"}, int'(cursor_row), r);
    endtask

    // Plotter model: acks after a chosen delay, or never while held; stray acks when idle.
    initial begin
        int cnt;
        int tgt;
        cnt = 0;
        tgt = 0;
        draw_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                draw_ack = 1'b0;
                cnt = 0;
            end else if (draw_req) begin
                if (hold_ack) begin
                    draw_ack = 1'b0;
                end else if (cnt >= tgt) begin
                    draw_ack = 1'b1;
                end else begin
                    draw_ack = 1'b0;
                    cnt++;
                end
            end else begin
                cnt = 0;
                tgt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                draw_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: compare each new plot request against the scoreboard, then check it holds.
    initial begin
        bit   prev;
        exp_t cur;
        prev = 1'b0;
        cur.x = 0; cur.y = 0; cur.c = 0;
        forever begin
            @(negedge clk);
            if (draw_req && !prev) begin
                rise_cnt++;
                last_x = int'(draw_x); last_y = int'(draw_y); last_c = int'(draw_char);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_draw actual x=%0d y=%0d c=%0d expected none",
                             draw_x, draw_y, draw_char);
                end else begin
                    cur = exp_q.pop_front();
                    chk("draw_x", int'(draw_x), cur.x);
                    chk("draw_y", int'(draw_y), cur.y);
                    chk("draw_char", int'(draw_char), cur.c);
                end
            end else if (draw_req && prev) begin
                chk("hold_x", int'(draw_x), cur.x);
                chk("hold_y", int'(draw_y), cur.y);
                chk("hold_char", int'(draw_char), cur.c);
            end
            prev = draw_req;
        end
    end

    initial begin
        int r0;
        int n;
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_ascii = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_draw_x", int'(draw_x), 0);
        chk("rst_draw_y", int'(draw_y), 0);
        chk("rst_draw_char", int'(draw_char), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk_cursor("rst", 0, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single key: request must appear three edges after the key is sampled.
        ack_delay = 2;
        key_valid = 1'b1;
        key_ascii = 7'h41;
        model_key(7'h41);
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_n1", int'(draw_req), 0);
        @(posedge clk); #1;
        chk("lat_n2", int'(draw_req), 0);
        @(posedge clk); #1;
        chk("lat_n3", int'(draw_req), 1);
        chk("lat_x", int'(draw_x), 0);
        chk("lat_char", int'(draw_char), 65);
        wait_drain();
        chk_cursor("after_a", 1, 0);

        // Bottom-right corner wrap.
        ack_delay = -1;
        type_keys(7'h0D, 14);
        type_keys(7'h00, 39);
        chk_cursor("corner", 39, 14);
        type_keys(7'h5A, 1);
        chk("corner_x", last_x, 312);
        chk("corner_y", last_y, 224);
        chk("corner_c", last_c, 90);
        chk_cursor("wrap", 0, 0);

        // Backspace across a row boundary.
        type_keys(7'h0D, 3);
        type_keys(7'h08, 1);
        chk("bs_x", last_x, 312);
        chk("bs_y", last_y, 32);
        chk("bs_c", last_c, 32);
        chk_cursor("bs", 39, 2);

        // CR on the last row wraps; a bell code does nothing.
        type_keys(7'h0D, 12);
        type_keys(7'h00, 5);
        chk_cursor("pre_cr", 5, 14);
        r0 = rise_cnt;
        burst_q.push_back(7'h0D);
        burst_q.push_back(7'h07);
        issue_burst(2);
        wait_drain();
        chk("cr_no_draw", rise_cnt - r0, 0);
        chk_cursor("cr", 0, 0);

        // Overflow: six keys while the plotter stalls; the sixth is lost.
        chk("ovf_before", int'(overflow), 0);
        hold_ack = 1'b1;
        r0 = rise_cnt;
        for (int i = 0; i < DEPTH + 2; i++) burst_q.push_back(rand_print());
        issue_burst(DEPTH + 1);
        repeat (10) @(negedge clk);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_req_held", int'(draw_req), 1);
        hold_ack = 1'b0;
        wait_drain();
        chk("ovf_draws", rise_cnt - r0, DEPTH + 1);
        chk_cursor("ovf", DEPTH + 1, 0);

        // Random mixed bursts.
        for (int b = 0; b < 20; b++) begin
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) burst_q.push_back(rand_key());
            issue_burst(n);
            wait_drain();
            chk_cursor("rand", mcol, mrow);
        end
        chk("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of a plot request.
        hold_ack = 1'b1;
        type_keys(7'h00, 0);
        burst_q.push_back(rand_print());
        issue_burst(1);
        n = 0;
        while (!draw_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_req_seen", int'(draw_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req", int'(draw_req), 0);
        chk("async_x", int'(draw_x), 0);
        chk("async_ovf", int'(overflow), 0);
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        hold_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r0 = rise_cnt;
        repeat (15) @(negedge clk);
        chk("post_rst_no_draw", rise_cnt - r0, 0);
        chk("post_rst_y", int'(draw_y), 0);
        chk("post_rst_char", int'(draw_char), 0);
        chk_cursor("post_rst", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
